// File: rtl/qspi_lat_pkg.sv
// Shared helpers for the QSPI read-latency delay line.
// Latency: n/a (constant functions and types only).
// Backpressure: none. The data path is a free-running shift register.
//
// Contents:
//   MAX_CS / CS_IDX_W : limits for the chip-select priority encoder.
//   clamp_lat         : saturates a requested latency at the number of stages.
//   sel_width         : width of a channel index, at least 1 bit.
//   first_set         : index of the lowest set bit, used as the cs_n priority encoder.
package qspi_lat_pkg;

  // The encoder works on a fixed-width request vector. Designs with up to
  // 32 chip selects fit without changes.
  localparam int MAX_CS   = 32;
  localparam int CS_IDX_W = $clog2(MAX_CS);

  function automatic int clamp_lat(input int lat, input int max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit 0 has the highest priority. Scanning from the top means the lowest
  // set bit is the one that is written last.
  function automatic logic [CS_IDX_W-1:0] first_set(input logic [MAX_CS-1:0] req);
    logic [CS_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CS - 1; i >= 0; i--) begin
      if (req[i]) idx = CS_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/qspi_lat_cfg_bank.sv
// Per-channel latency registers, with deferred (pending) writes.
// Latency: a write is visible 1 cycle after it is applied. A deferred write
//   is visible 1 cycle after the first cycle in which every chip select is high.
// Backpressure: none. Writes are never refused. A deferred write overwrites
//   any earlier pending value for the same channel.
//
// Ports:
//   clk, rst    : clock; synchronous active-high reset
//   all_desel   : every cs_n is high in this cycle (between transactions)
//   cfg_wr/sel/lat : write strobe, target channel, requested latency
//   lat         : effective latency of each channel
//   cfg_pending : per-channel flag, set while a deferred write is waiting
module qspi_lat_cfg_bank
  import qspi_lat_pkg::*;
#(
  parameter int NUM_CS      = 3,
  parameter int MAX_LAT     = 5,
  parameter int DEFAULT_LAT = 0,
  parameter int LAT_W       = $clog2(MAX_LAT + 1),
  parameter int SEL_W       = sel_width(NUM_CS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          all_desel,
  input  logic                          cfg_wr,
  input  logic [SEL_W-1:0]              cfg_sel,
  input  logic [LAT_W-1:0]              cfg_lat,
  output logic [NUM_CS-1:0][LAT_W-1:0]  lat,
  output logic [NUM_CS-1:0]             cfg_pending
);

  logic [LAT_W-1:0]             lat_clamped;
  logic [NUM_CS-1:0]            wr_hit;
  logic [NUM_CS-1:0][LAT_W-1:0] slot;

  assign lat_clamped = LAT_W'(clamp_lat(int'(cfg_lat), MAX_LAT));

  // A cfg_sel value of NUM_CS or more matches no channel, so the write is dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      wr_hit[i] = cfg_wr && (cfg_sel == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CS; i++) begin
        lat[i] <= LAT_W'(clamp_lat(DEFAULT_LAT, MAX_LAT));
      end
      slot        <= '0;
      cfg_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (all_desel) begin
          // A write made while the bus is idle has priority over a pending
          // value. It is the newer request.
          if (wr_hit[i]) begin
            lat[i] <= lat_clamped;
          end else if (cfg_pending[i]) begin
            lat[i] <= slot[i];
          end
          cfg_pending[i] <= 1'b0;
        end else if (wr_hit[i]) begin
          slot[i]        <= lat_clamped;
          cfg_pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/qspi_latency_line.sv
// Configurable read-latency delay line on the QSPI data-in path. Each chip
//   select has its own latency. The optional contention flag is built when
//   QSPI_LAT_CONTENTION_EN is defined.
// Latency: 0..MAX_LAT cycles, set for each channel. Latency 0 passes data through combinationally.
// Backpressure: none. The line shifts every cycle.
//
// Ports:
//   clk, rst       : clock; synchronous active-high reset
//   data_in        : raw QSPI data from the pads
//   cs_n           : active-low chip selects; bit 0 has the highest priority
//   cfg_wr/sel/lat : latency write strobe, target channel, latency value
//   data_out       : delayed data passed to the controller
//   lat_active     : latency currently applied to data_out
//   cfg_pending    : per-channel flag, set while a deferred write is waiting
//   contention     : sticky flag, set when more than one cs_n was low (tied to 0 without the macro)
module qspi_latency_line
  import qspi_lat_pkg::*;
#(
  parameter int DATA_W      = 4,
  parameter int MAX_LAT     = 5,
  parameter int NUM_CS      = 3,
  parameter int DEFAULT_LAT = 0,
  parameter int LAT_W       = $clog2(MAX_LAT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [NUM_CS-1:0]             cs_n,
  input  logic                          cfg_wr,
  input  logic [sel_width(NUM_CS)-1:0]  cfg_sel,
  input  logic [LAT_W-1:0]              cfg_lat,
  output logic [DATA_W-1:0]             data_out,
  output logic [LAT_W-1:0]              lat_active,
  output logic [NUM_CS-1:0]             cfg_pending,
  output logic                          contention
);

  localparam int SEL_W = sel_width(NUM_CS);

  logic [DATA_W-1:0]            stage [MAX_LAT];
  logic [NUM_CS-1:0][LAT_W-1:0] lat;
  logic [SEL_W-1:0]             act_sel;
  logic [SEL_W-1:0]             act_q;
  logic                         all_desel;

  assign all_desel = &cs_n;

  qspi_lat_cfg_bank #(
    .NUM_CS      (NUM_CS),
    .MAX_LAT     (MAX_LAT),
    .DEFAULT_LAT (DEFAULT_LAT),
    .LAT_W       (LAT_W),
    .SEL_W       (SEL_W)
  ) u_cfg_bank (
    .clk         (clk),
    .rst         (rst),
    .all_desel   (all_desel),
    .cfg_wr      (cfg_wr),
    .cfg_sel     (cfg_sel),
    .cfg_lat     (cfg_lat),
    .lat         (lat),
    .cfg_pending (cfg_pending)
  );

  // Delay line. Stale stages are not flushed when the latency changes,
  // because latency changes only happen between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAX_LAT; k++) stage[k] <= '0;
    end else begin
      stage[0] <= data_in;
      for (int k = 1; k < MAX_LAT; k++) stage[k] <= stage[k-1];
    end
  end

  // The new channel is selected combinationally, so the tap changes in the
  // same cycle that its cs_n falls. The last channel is held while the bus is idle.
  always_comb begin
    act_sel = act_q;
    if (!all_desel) act_sel = SEL_W'(first_set(MAX_CS'(~cs_n)));
  end

  always_ff @(posedge clk) begin
    if (rst) act_q <= '0;
    else     act_q <= act_sel;
  end

  assign lat_active = lat[act_sel];

  // Tap mux. Latency 0 falls through to the combinational bypass.
  always_comb begin
    data_out = data_in;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (lat_active == LAT_W'(k + 1)) data_out = stage[k];
    end
  end

`ifdef QSPI_LAT_CONTENTION_EN
  logic multi_sel;
  assign multi_sel = $countones(~cs_n) > 1;

  always_ff @(posedge clk) begin
    if (rst)            contention <= 1'b0;
    else if (multi_sel) contention <= 1'b1;
  end
`else
  assign contention = 1'b0;
`endif

endmodule
